// File: rtl/burst_ctrl_pkg.sv
// Shared definitions for burst_ctrl: conversion mode encodings and FSM state type.
package burst_ctrl_pkg;

    localparam logic [1:0] MODE_PASS     = 2'b00;
    localparam logic [1:0] MODE_ONES     = 2'b01;
    localparam logic [1:0] MODE_MAG      = 2'b10;
    localparam logic [1:0] MODE_PASS_ALT = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/burst_conv.sv
// Combinational word conversion applied on the capture path of burst_ctrl.
module burst_conv
    import burst_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] conv_data
);

    logic msb;

    assign msb = data[WIDTH-1];

    always_comb begin
        conv_data = data;
        case (mode)
            MODE_ONES: begin
                if (msb) conv_data = ~data;
            end
            // Two's-complement magnitude; the most negative value maps to itself.
            MODE_MAG: begin
                if (msb) conv_data = ~data + WIDTH'(1);
            end
            default: conv_data = data;
        endcase
    end

endmodule

// File: rtl/burst_ctrl.sv
// Captures one converted word and replays it as a BURST_LEN-beat valid/ready burst.
// Define BURST_CTRL_REMAIN_EN to add the out_remaining beat-count output.
module burst_ctrl
    import burst_ctrl_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int BURST_LEN = 15,
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
`ifdef BURST_CTRL_REMAIN_EN
    ,
    output logic [CNT_W-1:0] out_remaining
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] conv_w;
    logic             capture;
    logic             xfer;

    burst_conv #(
        .WIDTH(WIDTH)
    ) u_conv (
        .data     (in_data),
        .mode     (mode),
        .conv_data(conv_w)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // in_ready is gated by reset so nothing is accepted while reset is held.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        xfer      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !reset;
                capture  = in_valid && !reset;
                if (capture) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                xfer      = out_ready;
                if (xfer && remaining == CNT_W'(1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            remaining <= '0;
        end else if (capture) begin
            data_q    <= conv_w;
            remaining <= CNT_W'(BURST_LEN);
        end else if (xfer) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign out_data = data_q;
    assign out_last = out_valid && (remaining == CNT_W'(1));

`ifdef BURST_CTRL_REMAIN_EN
    assign out_remaining = busy ? remaining : '0;
`endif

endmodule

// File: tb/tb_burst_ctrl.sv
// Self-checking bench for burst_ctrl (BURST_LEN 15 instance plus a BURST_LEN 1 instance).
module tb_burst_ctrl;

    localparam int LEN = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [1:0] mode;
    logic       in_valid, out_ready;
    logic       in_ready, out_valid, out_last, busy;
    logic [7:0] out_data;
    logic       in_valid1, out_ready1;
    logic       in_ready1, out_valid1, out_last1, busy1;
    logic [7:0] out_data1;
`ifdef BURST_CTRL_REMAIN_EN
    logic [3:0] out_rem;
    logic [0:0] out_rem1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    burst_ctrl #(.WIDTH(8), .BURST_LEN(LEN)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy)
`ifdef BURST_CTRL_REMAIN_EN
        , .out_remaining(out_rem)
`endif
    );

    burst_ctrl #(.WIDTH(8), .BURST_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1),
        .in_ready(in_ready1), .mode(mode), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
        .busy(busy1)
`ifdef BURST_CTRL_REMAIN_EN
        , .out_remaining(out_rem1)
`endif
    );

    // Reference conversion written from the arithmetic definition of each mode.
    function automatic logic [7:0] ref_conv(input int x, input int m);
        if (m == 1 && x >= 128) return 8'(255 - x);
        if (m == 2 && x >= 128) return 8'((256 - x) % 256);
        return 8'(x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle. rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic burst(input int d, input int m, input int rmode, input bit hold,
                         input int nd, input int nm, input int abort_after);
        logic [7:0] exp;
        int sent;
        int cyc;
        bit rdy;
        exp  = ref_conv(d, m);
        sent = 0;
        cyc  = 0;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d[7:0];
        mode     = m[1:0];
        tick();
        if (hold) begin
            in_data = nd[7:0];
            mode    = nm[1:0];
        end else begin
            in_valid = 1'b0;
        end
        while (sent < LEN && cyc < LEN * 10) begin
            chk("out_valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("in_ready_emit", in_ready, 0);
            chk("out_data", out_data, exp);
            chk("out_last", out_last, (sent == LEN - 1));
`ifdef BURST_CTRL_REMAIN_EN
            chk("out_remaining", out_rem, LEN - sent);
`endif
            if (abort_after > 0 && sent == abort_after) begin
                reset     = 1'b1;
                in_valid  = 1'b1;
                in_data   = 8'h11;
                out_ready = 1'b1;
                tick();
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_in_ready", in_ready, 0);
                reset    = 1'b0;
                in_valid = 1'b0;
                tick();
                chk("rel_in_ready", in_ready, 1);
                chk("rel_out_valid", out_valid, 0);
                chk("rel_busy", busy, 0);
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            tick();
            cyc++;
            if (rdy) sent++;
        end
        if (sent < LEN) chk("burst_timeout", sent, LEN);
        chk("end_out_valid", out_valid, 0);
        chk("end_out_last", out_last, 0);
        chk("end_busy", busy, 0);
        chk("end_in_ready", in_ready, 1);
`ifdef BURST_CTRL_REMAIN_EN
        chk("end_out_remaining", out_rem, 0);
`endif
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        in_data    = '0;
        mode       = '0;
        out_ready  = 1'b1;
        out_ready1 = 1'b0;
        tick();
        tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        chk("post_reset_in_ready", in_ready, 1);

        // Directed conversions with a steady sink.
        burst(8'h85, 1, 0, 1'b0, 0, 0, 0);
        burst(8'hFE, 2, 0, 1'b0, 0, 0, 0);
        burst(8'h80, 2, 0, 1'b0, 0, 0, 0);
        burst(8'hFE, 0, 0, 1'b0, 0, 0, 0);
        burst(8'hC3, 3, 0, 1'b0, 0, 0, 0);
        burst(8'h45, 1, 0, 1'b0, 0, 0, 0);

        // Backpressure pattern 1,0,0,1.
        burst(8'hA7, 1, 1, 1'b0, 0, 0, 0);

        // New word offered throughout the burst; taken only once the burst ends.
        burst(8'h3C, 0, 0, 1'b1, 8'hF0, 2, 0);
        burst(8'hF0, 2, 0, 1'b0, 0, 0, 0);

        // Reset after five beats.
        burst(8'h9A, 1, 0, 1'b0, 0, 0, 5);

        // Random words, modes and sink behaviour.
        for (int i = 0; i < 6; i++) begin
            int gap;
            burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 2, 1'b0, 0, 0, 0);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_out_valid", out_valid, 0);
            end
        end

        // Single-beat instance.
        chk("len1_in_ready", in_ready1, 1);
        in_valid1  = 1'b1;
        in_data    = 8'h85;
        mode       = 2'd1;
        out_ready1 = 1'b0;
        tick();
        in_valid1 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("len1_out_valid", out_valid1, 1);
            chk("len1_out_last", out_last1, 1);
            chk("len1_out_data", out_data1, ref_conv(8'h85, 1));
            chk("len1_busy", busy1, 1);
`ifdef BURST_CTRL_REMAIN_EN
            chk("len1_out_remaining", out_rem1, 1);
`endif
            if (s == 1) out_ready1 = 1'b1;
            tick();
        end
        chk("len1_end_out_valid", out_valid1, 0);
        chk("len1_end_out_last", out_last1, 0);
        chk("len1_end_in_ready", in_ready1, 1);
        chk("len1_end_busy", busy1, 0);
`ifdef BURST_CTRL_REMAIN_EN
        chk("len1_end_out_remaining", out_rem1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/burst_ctrl.md
BURST_CTRL -- requirements
Module: burst_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (2..32).
REQ-002 Parameter BURST_LEN, default 15, output beats per captured word (1..255).
REQ-003 Derived constant CNT_W = clog2(BURST_LEN+1), width of the beat counter.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  WIDTH  word to capture.
REQ-007 in_valid  input  1  in_data/mode valid.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 mode  input  2  conversion select: 00 pass, 01 ones-complement if MSB set, 10 two's-complement magnitude if MSB set, 11 pass.
REQ-010 out_data  output  WIDTH  converted word.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_last  output  1  current beat is final beat of burst.
REQ-014 busy  output  1  burst in progress.

Function
REQ-015 FSM states IDLE and EMIT; in_ready = 1 only in IDLE; busy = 1 only in EMIT.
REQ-016 Capture when in_valid && in_ready: register converted in_data and go to EMIT, remaining count = BURST_LEN; mode sampled only at capture.
REQ-017 out_valid asserts the cycle after capture (latency 1) and stays high throughout EMIT.
REQ-018 Beat transfers on a cycle with out_valid && out_ready; remaining decrements by 1 per transfer.
REQ-019 out_data and out_last held stable while out_valid && !out_ready.
REQ-020 out_last = 1 exactly when out_valid and remaining == 1.
REQ-021 Transfer of last beat returns FSM to IDLE next cycle; out_valid and out_last deassert; in_ready reasserts.
REQ-022 in_valid during EMIT ignored; no capture, no state change; earliest next capture is the cycle after return to IDLE.
REQ-023 Conversion mode 01: MSB set -> bitwise inversion of all WIDTH bits, else unchanged.
REQ-024 Conversion mode 10: MSB set -> (~x + 1) truncated to WIDTH, read as unsigned magnitude (0x80 -> 0x80 for WIDTH 8), else unchanged.
REQ-025 BURST_LEN = 1: single beat, out_last high on that beat.

Reset
REQ-026 reset high on a rising edge: state IDLE, out_valid 0, out_last 0, out_data 0, remaining 0, busy 0.
REQ-027 in_ready = 0 while reset is high; in_valid ignored during reset.
REQ-028 Reset mid-burst aborts burst immediately; no further beats; in_ready = 1 the first cycle after reset drops.

Configuration
REQ-029 Macro BURST_CTRL_REMAIN_EN defined: extra output out_remaining (CNT_W bits) = beats left including current, 0 in IDLE.
REQ-030 Macro BURST_CTRL_REMAIN_EN undefined: port out_remaining absent; all other behaviour identical.

Structure
REQ-031 Package burst_ctrl_pkg holds mode encoding constants (MODE_PASS, MODE_ONES, MODE_MAG) and state encoding type.
REQ-032 Conversion in sub-module burst_conv (combinational, parameter WIDTH, inputs data and mode, output converted data), instantiated once at capture path.

Verification
REQ-033 WIDTH 8, BURST_LEN 15, out_ready=1, mode 01, in_data 0x85 -> 15 beats of 0x7A on consecutive cycles starting 1 cycle after capture, out_last on beat 15 only.
REQ-034 mode 10, in_data 0xFE -> 0x02 each beat; in_data 0x80 -> 0x80; mode 00 in_data 0xFE -> 0xFE.
REQ-035 out_ready toggled 1,0,0,1 repeating -> exactly 15 transfers, out_data stable during stalls, busy high until last transfer.
REQ-036 in_valid held high with new data during EMIT -> word ignored; new word captured first cycle after burst end, in_ready high that cycle.
REQ-037 reset asserted after beat 5 -> out_valid 0 next cycle, no further beats, in_ready 1 after reset release.
REQ-038 BURST_LEN 1 and BURST_CTRL_REMAIN_EN defined -> single beat with out_last 1, out_remaining 1 then 0.
